ide_pio_sequencer: RTL and testbench
====================================

Name: ide_pio_sequencer

Overview:
Sequences a single 68000 bus cycle that has already been decoded as an IDE register access into correctly timed ATA PIO strobes. It drives chip-select setup, the IOR_n/IOW_n pulse width, hold, the DTACK request and recovery time, with the pulse width and recovery taken from a small run-time timing register. It sits between the Zorro II decode (ide_access) and the IDE connector, in the CLK7M domain, and replaces fixed-width strobe generation.

Parameters:
SETUP_CYCLES, 1, CS-valid-to-strobe cycles (t1); legal range 1-3.
DEFAULT_CFG, 4'b1111, timing register value after reset (slowest, PIO0-safe).
MIN_STROBE, 2, base strobe width in cycles; the cfg[1:0] field adds to this.

Ports:
CLK  in  1  CLK7M bus clock (~141 ns)
RESET_n  in  1  asynchronous active-low reset
AS_n  in  1  68000 address strobe
RW  in  1  1 = read
UDS_n  in  1  upper data strobe
LDS_n  in  1  lower data strobe
ide_access  in  1  address decoded to IDE register space
ide_enable  in  1  IDE function enabled
cs_sel  in  1  0 = CS1 block, 1 = CS2 block (from address)
cfg_we  in  1  one-cycle timing-register write strobe
cfg_din  in  4  [1:0] extra strobe cycles, [3:2] recovery cycles
IDECS1_n  out  1  ATA CS0
IDECS2_n  out  1  ATA CS1
IOR_n  out  1  ATA read strobe
IOW_n  out  1  ATA write strobe
DTACK  out  1  request DTACK (active high; top gates it onto the bus)
rd_latch  out  1  one-cycle pulse: capture IDE read data
busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, CLK. RESET_n is asynchronous and active-low. All outputs are registered.
- Reset values: IDECS1_n=1, IDECS2_n=1, IOR_n=1, IOW_n=1, DTACK=0, rd_latch=0, busy=0, cfg=DEFAULT_CFG, state=IDLE.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER.
- Start condition: ide_enable && ide_access && !AS_n && (!UDS_n || !LDS_n), sampled at a rising CLK edge.
- IDLE:
  - On the start condition, latch RW and cs_sel and go to SETUP.
  - Otherwise all outputs stay idle.
- SETUP:
  - Selected CS asserted low from the first SETUP cycle.
  - Timer loaded with SETUP_CYCLES; go to STROBE after it expires.
  - AS_n high here = abort: go to RECOVER with no strobe issued.
- STROBE:
  - IOR_n (read) or IOW_n (write) is low for exactly MIN_STROBE + cfg[1:0] cycles, i.e. 2-5.
  - On a read, rd_latch pulses on the final STROBE cycle.
  - Then go to HOLD.
  - AS_n high here = abort: drop the strobe on the next edge and go to HOLD.
- HOLD:
  - Strobe high, CS still asserted; gives at least one cycle of CS hold.
  - DTACK=1 while AS_n is low.
  - When AS_n is sampled high: DTACK=0, go to RECOVER.
  - An aborted cycle never asserts DTACK.
- RECOVER:
  - CS deasserted.
  - Stays cfg[3:2] further cycles (0-3), then IDLE.
  - New requests are not accepted until IDLE.
  - Minimum idle-to-idle time with default cfg: 1 SETUP + 5 STROBE + 1 HOLD + 1 RECOVER + 3 = 11 cycles.
- Timing register:
  - Written on cfg_we in any state.
  - Counts are loaded on state entry, so a write mid-cycle takes effect at the next loaded count.
  - Reset overrides cfg_we.
- Back-to-back accesses: when AS_n falls again during RECOVER, the cycle starts from IDLE. DTACK is delayed accordingly and never early.
- ide_enable low mid-cycle: the current cycle completes normally. It only gates starts.
- RESET_n low mid-cycle: all outputs return to their reset values immediately (asynchronously). There is no partial strobe extension.
- Only one of IOR_n/IOW_n and one CS may be low at any time. Strobe low implies CS low.

Decomposition:
- Package ripple_ide_pkg:
  - state enum (IDLE, SETUP, STROBE, HOLD, RECOVER)
  - cfg field positions (STB_LSB=0, REC_LSB=2)
  - DEFAULT_CFG constant
  - timer width constant (3 bits)
- Sub-module ide_cycle_timer: 3-bit loadable down-counter with load, value and a done flag. One instance is shared across SETUP, STROBE and RECOVER.

Test Plan:
- Default-cfg read, cs_sel=0: AS_n low with UDS_n low, RW=1 -> IDECS1_n low 1 cycle before IOR_n; IOR_n low exactly 5 cycles; rd_latch on the 5th; DTACK in HOLD until AS_n high; IDLE 4 cycles later.
- Write with cfg_din=4'b0000 loaded, cs_sel=1 -> IDECS2_n used, IOW_n low exactly 2 cycles, RECOVER of 1 cycle; IOR_n stays 1 throughout.
- Abort: raise AS_n in the 2nd STROBE cycle -> strobe high next edge, DTACK never asserted, CS released after the HOLD cycle.
- Abort in SETUP -> no strobe ever asserted; RECOVER then IDLE; busy falls after cfg[3:2]+1 cycles.
- Mid-cycle cfg write to 4'b0001 during STROBE of a default read -> current strobe still 5 cycles; next access strobe is 3 cycles.
- RESET_n pulsed low during STROBE -> IOR_n, CS, DTACK and busy return to idle values asynchronously; cfg=4'b1111; a fresh access afterwards behaves as in scenario 1.

Source files
------------

// File: rtl/ripple_ide_pkg.sv
// Shared types and constants for the IDE PIO strobe sequencer.
// Timing register layout: [1:0] extra strobe cycles, [3:2] recovery cycles.
package ripple_ide_pkg;

  localparam int TMR_W   = 3;
  localparam int STB_LSB = 0;
  localparam int REC_LSB = 2;

  localparam logic [3:0] DEFAULT_CFG = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } state_e;

endpackage

// File: rtl/ide_cycle_timer.sv
// Loadable down-counter that holds at zero; done flags the last cycle of a phase.
// Load wins over counting; a loaded value N gives N+1 cycles until done clears the phase.
module ide_cycle_timer
  import ripple_ide_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic [TMR_W-1:0] value_o,
  output logic             done_o
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value_o = cnt_q;
  assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/ide_pio_sequencer.sv
// Turns one decoded 68000 IDE access into timed ATA PIO CS/IOR/IOW strobes plus a DTACK request.
// Outputs registered, one edge after the deciding sample; bus side waits on DTACK, no other backpressure.
module ide_pio_sequencer #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter logic [3:0]  DEFAULT_CFG  = ripple_ide_pkg::DEFAULT_CFG,
  parameter int unsigned MIN_STROBE   = 2
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       AS_n,
  input  logic       RW,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       ide_access,
  input  logic       ide_enable,
  input  logic       cs_sel,
  input  logic       cfg_we,
  input  logic [3:0] cfg_din,
  output logic       IDECS1_n,
  output logic       IDECS2_n,
  output logic       IOR_n,
  output logic       IOW_n,
  output logic       DTACK,
  output logic       rd_latch,
  output logic       busy
);
  import ripple_ide_pkg::*;

  // Timer loads are phase length minus one, since the timer is done on its zero cycle.
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] STB_BASE = TMR_W'(MIN_STROBE - 1);

  state_e           state_q, state_d;
  logic             rw_q, rw_d, sel_q, sel_d, aborted_q, aborted_d;
  logic [3:0]       cfg_q;
  logic             cs1_n_q, cs1_n_d, cs2_n_q, cs2_n_d;
  logic             ior_n_q, ior_n_d, iow_n_q, iow_n_d;
  logic             dtack_q, dtack_d, rd_latch_q, rd_latch_d, busy_q, busy_d;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val, tmr_cnt, stb_ld, rec_ld;
  logic             start, cs_on, stb_on;

  assign start  = ide_enable && ide_access && !AS_n && (!UDS_n || !LDS_n);
  assign stb_ld = STB_BASE + TMR_W'(cfg_q[STB_LSB +: 2]);
  assign rec_ld = TMR_W'(cfg_q[REC_LSB +: 2]);

  ide_cycle_timer u_timer (
    .clk_i      (CLK),
    .rst_ni     (RESET_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .value_o    (tmr_cnt),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    sel_d     = sel_q;
    aborted_d = aborted_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d   = SETUP;
        rw_d      = RW;
        sel_d     = cs_sel;
        aborted_d = 1'b0;
        tmr_load  = 1'b1;
        tmr_val   = SETUP_LD;
      end
      SETUP: if (AS_n) begin
        state_d   = RECOVER;
        aborted_d = 1'b1;
        tmr_load  = 1'b1;
        tmr_val   = rec_ld;
      end else if (tmr_done) begin
        state_d  = STROBE;
        tmr_load = 1'b1;
        tmr_val  = stb_ld;
      end
      // An abort skips the rest of the strobe but still passes through HOLD for CS hold time.
      STROBE: if (AS_n) begin
        state_d   = HOLD;
        aborted_d = 1'b1;
      end else if (tmr_done) begin
        state_d = HOLD;
      end
      HOLD: if (AS_n) begin
        state_d  = RECOVER;
        tmr_load = 1'b1;
        tmr_val  = rec_ld;
      end
      RECOVER: if (tmr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_on      = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    stb_on     = (state_d == STROBE);
    cs1_n_d    = !(cs_on && !sel_d);
    cs2_n_d    = !(cs_on && sel_d);
    ior_n_d    = !(stb_on && rw_d);
    iow_n_d    = !(stb_on && !rw_d);
    dtack_d    = (state_d == HOLD) && !aborted_d;
    rd_latch_d = rw_q && (state_q == STROBE) && (state_d == STROBE) && (tmr_cnt == TMR_W'(1));
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= IDLE;
      rw_q       <= 1'b1;
      sel_q      <= 1'b0;
      aborted_q  <= 1'b0;
      cfg_q      <= DEFAULT_CFG;
      cs1_n_q    <= 1'b1;
      cs2_n_q    <= 1'b1;
      ior_n_q    <= 1'b1;
      iow_n_q    <= 1'b1;
      dtack_q    <= 1'b0;
      rd_latch_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      sel_q      <= sel_d;
      aborted_q  <= aborted_d;
      if (cfg_we) cfg_q <= cfg_din;
      cs1_n_q    <= cs1_n_d;
      cs2_n_q    <= cs2_n_d;
      ior_n_q    <= ior_n_d;
      iow_n_q    <= iow_n_d;
      dtack_q    <= dtack_d;
      rd_latch_q <= rd_latch_d;
      busy_q     <= busy_d;
    end
  end

  assign IDECS1_n = cs1_n_q;
  assign IDECS2_n = cs2_n_q;
  assign IOR_n    = ior_n_q;
  assign IOW_n    = iow_n_q;
  assign DTACK    = dtack_q;
  assign rd_latch = rd_latch_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Directed bench for ide_pio_sequencer: a per-cycle vector table for a default read,
// then hand-written sequences for writes, aborts, mid-cycle cfg writes and async reset.
module tb_ide_pio_sequencer;

  logic       CLK, RESET_n, AS_n, RW, UDS_n, LDS_n;
  logic       ide_access, ide_enable, cs_sel, cfg_we;
  logic [3:0] cfg_din;
  logic       IDECS1_n, IDECS2_n, IOR_n, IOW_n, DTACK, rd_latch, busy;

  int n_cmp = 0;
  int n_bad = 0;

  ide_pio_sequencer dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .AS_n       (AS_n),
    .RW         (RW),
    .UDS_n      (UDS_n),
    .LDS_n      (LDS_n),
    .ide_access (ide_access),
    .ide_enable (ide_enable),
    .cs_sel     (cs_sel),
    .cfg_we     (cfg_we),
    .cfg_din    (cfg_din),
    .IDECS1_n   (IDECS1_n),
    .IDECS2_n   (IDECS2_n),
    .IOR_n      (IOR_n),
    .IOW_n      (IOW_n),
    .DTACK      (DTACK),
    .rd_latch   (rd_latch),
    .busy       (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Output vector order: {IDECS1_n, IDECS2_n, IOR_n, IOW_n, DTACK, rd_latch, busy}
  localparam logic [6:0] IDLE_V = 7'b1111000;

  function automatic logic [6:0] outs();
    return {IDECS1_n, IDECS2_n, IOR_n, IOW_n, DTACK, rd_latch, busy};
  endfunction

  function automatic logic [6:0] ev(input bit cs_on, input bit sel, input bit stb,
                                    input bit rd, input bit dtk, input bit rdl, input bit bsy);
    return {!(cs_on && !sel), !(cs_on && sel), !(stb && rd), !(stb && !rd), dtk, rdl, bsy};
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cs1,cs2,ior,iow,dtack,rdl,busy)", nm, act, exp);
    end
  endtask

  task automatic cyc(input string nm, input logic [6:0] exp);
    @(posedge CLK);
    #1;
    chk(nm, outs(), exp);
  endtask

  task automatic wr_cfg(input logic [3:0] v);
    cfg_din = v;
    cfg_we  = 1'b1;
    cyc("cfg_write_idle", IDLE_V);
    cfg_we  = 1'b0;
  endtask

  task automatic bus_idle();
    AS_n  = 1'b1;
    UDS_n = 1'b1;
    LDS_n = 1'b1;
  endtask

  task automatic run_access(input string nm, input bit rd, input bit sel, input int nstb,
                            input int nhold, input int nrec, input int cfg_at,
                            input logic [3:0] cfg_val);
    AS_n   = 1'b0;
    RW     = rd;
    cs_sel = sel;
    if (rd) UDS_n = 1'b0;
    else    LDS_n = 1'b0;
    cyc({nm, "/setup"}, ev(1, sel, 0, rd, 0, 0, 1));
    for (int i = 0; i < nstb; i++) begin
      if (i == cfg_at) begin
        cfg_din = cfg_val;
        cfg_we  = 1'b1;
      end
      cyc({nm, "/strobe"}, ev(1, sel, 1, rd, 0, rd && (i == nstb - 1), 1));
      cfg_we = 1'b0;
    end
    for (int h = 0; h < nhold; h++) cyc({nm, "/hold"}, ev(1, sel, 0, rd, 1, 0, 1));
    bus_idle();
    for (int r = 0; r < nrec; r++) cyc({nm, "/recover"}, ev(0, sel, 0, rd, 0, 0, 1));
    cyc({nm, "/idle"}, IDLE_V);
  endtask

  typedef struct {
    logic       as_n;
    logic       rw;
    logic       sel;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Default-cfg read on CS1: 1 setup, 5 strobe, 2 hold, 4 recover.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 7'b1111000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 7'b0111001};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 7'b0101001};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 7'b0101001};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 7'b0101001};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 7'b0101001};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 7'b0101011};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 7'b0111101};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 7'b0111101};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 7'b1111001};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 7'b1111001};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 7'b1111001};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 7'b1111001};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 7'b1111000};

    RESET_n    = 1'b0;
    bus_idle();
    RW         = 1'b1;
    ide_access = 1'b1;
    ide_enable = 1'b1;
    cs_sel     = 1'b0;
    cfg_we     = 1'b0;
    cfg_din    = 4'b0000;
    #12;
    chk("reset_values", outs(), IDLE_V);
    RESET_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      AS_n   = tbl[i].as_n;
      UDS_n  = tbl[i].as_n;
      LDS_n  = 1'b1;
      RW     = tbl[i].rw;
      cs_sel = tbl[i].sel;
      cyc($sformatf("table_read_v%0d", i), tbl[i].exp);
    end

    // Starts are gated by ide_enable.
    ide_enable = 1'b0;
    AS_n  = 1'b0;
    UDS_n = 1'b0;
    cyc("enable_gates_start", IDLE_V);
    cyc("enable_gates_start2", IDLE_V);
    bus_idle();
    ide_enable = 1'b1;
    cyc("enable_restored_idle", IDLE_V);

    // Fastest write on CS2.
    wr_cfg(4'b0000);
    run_access("fast_write_cs2", 1'b0, 1'b1, 2, 1, 1, -1, 4'b0000);

    // Abort in the second strobe cycle: no DTACK, CS held through one HOLD cycle.
    wr_cfg(4'b0011);
    AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b1; cs_sel = 1'b0;
    cyc("abort_stb/setup", 7'b0111001);
    cyc("abort_stb/stb1", 7'b0101001);
    cyc("abort_stb/stb2", 7'b0101001);
    bus_idle();
    cyc("abort_stb/hold_no_dtack", 7'b0111001);
    cyc("abort_stb/recover", 7'b1111001);
    cyc("abort_stb/idle", IDLE_V);

    // Abort in SETUP with two extra recovery cycles.
    wr_cfg(4'b1000);
    AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b1; cs_sel = 1'b0;
    cyc("abort_setup/setup", 7'b0111001);
    bus_idle();
    for (int r = 0; r < 3; r++) cyc("abort_setup/recover", 7'b1111001);
    cyc("abort_setup/idle", IDLE_V);

    // Mid-strobe cfg write: current strobe keeps 5, recovery and next access use the new value.
    wr_cfg(4'b1111);
    run_access("midcfg_cur", 1'b1, 1'b0, 5, 2, 1, 1, 4'b0001);
    run_access("midcfg_next", 1'b1, 1'b0, 3, 1, 1, -1, 4'b0000);

    // Asynchronous reset during STROBE.
    AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b1; cs_sel = 1'b0;
    cyc("rst_mid/setup", 7'b0111001);
    cyc("rst_mid/stb1", 7'b0101001);
    #2;
    RESET_n = 1'b0;
    #1;
    chk("rst_mid/async_idle", outs(), IDLE_V);
    bus_idle();
    @(posedge CLK);
    #1;
    chk("rst_mid/held_idle", outs(), IDLE_V);
    RESET_n = 1'b1;
    run_access("post_reset_read", 1'b1, 1'b0, 5, 1, 4, -1, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
